rpn_operand_stack: RTL and testbench

//   Operand stack for the RPN calculator: the reader/consumer side of the load-enable register bank.

---
 rtl/rpn_operand_stack.sv | 168 ++++++++++++++++
 tb/tb_rpn_operand_stack.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/rpn_operand_stack.sv
// Operand stack for the RPN calculator: push / pop / reduce with sticky overflow/underflow
// error state. Top two entries are presented to the ALU from registers.
module rpn_operand_stack #(
  parameter  int K     = 16,
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    cmd,
  input  logic [K-1:0]  din,
  input  logic          clear_err,
  output logic [K-1:0]  top,
  output logic [K-1:0]  second,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          err,
  output logic [1:0]    err_code
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] CMD_NOP    = 2'b00;
  localparam logic [1:0] CMD_PUSH   = 2'b01;
  localparam logic [1:0] CMD_POP    = 2'b10;
  localparam logic [1:0] CMD_REDUCE = 2'b11;

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_OVF  = 2'b01;
  localparam logic [1:0] CODE_UNF  = 2'b10;

  localparam logic [CW-1:0] ZERO_C  = CW'(32'd0);
  localparam logic [CW-1:0] ONE_C   = CW'(32'd1);
  localparam logic [CW-1:0] TWO_C   = CW'(32'd2);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [0:0] {
    ST_RUN = 1'b0,
    ST_ERR = 1'b1
  } state_t;

  logic [K-1:0]  mem_r     [DEPTH];
  logic [K-1:0]  mem_nxt_s [DEPTH];
  logic [CW-1:0] count_r, count_nxt_s;
  state_t        state_r, state_nxt_s;
  logic [1:0]    code_r, code_nxt_s;
  logic [K-1:0]  top_r, second_r, top_nxt_s, second_nxt_s;
  logic          full_r, empty_r, err_r;
  logic [IW-1:0] wr_idx_s, cm1_idx_s, cm2_idx_s, nt_idx_s, ns_idx_s;

  // Slot indices relative to the current and the next depth; only used where in range.
  assign wr_idx_s  = count_r[IW-1:0];
  assign cm1_idx_s = IW'(count_r - ONE_C);
  assign cm2_idx_s = IW'(count_r - TWO_C);
  assign nt_idx_s  = IW'(count_nxt_s - ONE_C);
  assign ns_idx_s  = IW'(count_nxt_s - TWO_C);

  // Next stack contents, depth and FSM state from the command.
  always_comb begin
    mem_nxt_s   = mem_r;
    count_nxt_s = count_r;
    state_nxt_s = state_r;
    code_nxt_s  = code_r;
    case (state_r)
      ST_RUN: begin
        case (cmd)
          CMD_PUSH: begin
            if (count_r < DEPTH_C) begin
              mem_nxt_s[wr_idx_s] = din;
              count_nxt_s         = count_r + ONE_C;
            end else begin
              state_nxt_s = ST_ERR;
              code_nxt_s  = CODE_OVF;
            end
          end
          CMD_POP: begin
            if (count_r >= ONE_C) begin
              mem_nxt_s[cm1_idx_s] = {K{1'b0}};
              count_nxt_s          = count_r - ONE_C;
            end else begin
              state_nxt_s = ST_ERR;
              code_nxt_s  = CODE_UNF;
            end
          end
          CMD_REDUCE: begin
            if (count_r >= TWO_C) begin
              mem_nxt_s[cm2_idx_s] = din;
              mem_nxt_s[cm1_idx_s] = {K{1'b0}};
              count_nxt_s          = count_r - ONE_C;
            end else begin
              state_nxt_s = ST_ERR;
              code_nxt_s  = CODE_UNF;
            end
          end
          CMD_NOP: begin
            state_nxt_s = ST_RUN;
          end
          default: begin
            state_nxt_s = ST_RUN;
          end
        endcase
      end
      ST_ERR: begin
        // A clear wins over any command issued alongside it; the stack stays frozen.
        if (clear_err) begin
          state_nxt_s = ST_RUN;
          code_nxt_s  = CODE_NONE;
        end else begin
          state_nxt_s = ST_ERR;
        end
      end
      default: begin
        state_nxt_s = ST_ERR;
      end
    endcase
  end

  // X / Y views of the next stack, so they can be registered alongside it.
  always_comb begin
    if (count_nxt_s >= ONE_C) begin
      top_nxt_s = mem_nxt_s[nt_idx_s];
    end else begin
      top_nxt_s = {K{1'b0}};
    end
    if (count_nxt_s >= TWO_C) begin
      second_nxt_s = mem_nxt_s[ns_idx_s];
    end else begin
      second_nxt_s = {K{1'b0}};
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {K{1'b0}};
      end
      count_r  <= ZERO_C;
      state_r  <= ST_RUN;
      code_r   <= CODE_NONE;
      top_r    <= {K{1'b0}};
      second_r <= {K{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      err_r    <= 1'b0;
    end else begin
      mem_r    <= mem_nxt_s;
      count_r  <= count_nxt_s;
      state_r  <= state_nxt_s;
      code_r   <= code_nxt_s;
      top_r    <= top_nxt_s;
      second_r <= second_nxt_s;
      full_r   <= (count_nxt_s == DEPTH_C);
      empty_r  <= (count_nxt_s == ZERO_C);
      err_r    <= (state_nxt_s == ST_ERR);
    end
  end

  assign top      = top_r;
  assign second   = second_r;
  assign count    = count_r;
  assign full     = full_r;
  assign empty    = empty_r;
  assign err      = err_r;
  assign err_code = code_r;

endmodule

// File: tb/tb_rpn_operand_stack.sv
// Scoreboard bench for rpn_operand_stack: a queue-based stack model predicts every cycle,
// a separate monitor compares the registered outputs one cycle after each command edge.
module tb_rpn_operand_stack;

  localparam int K     = 16;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] PSH = 2'b01;
  localparam logic [1:0] POP = 2'b10;
  localparam logic [1:0] RED = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    cmd = 2'b00;
  logic [K-1:0]  din = '0;
  logic          clear_err = 1'b0;
  logic [K-1:0]  top, second;
  logic [CW-1:0] count;
  logic          full, empty, err;
  logic [1:0]    err_code;

  always #5 clk = ~clk;

  rpn_operand_stack #(.K(K), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .din(din), .clear_err(clear_err),
    .top(top), .second(second), .count(count), .full(full), .empty(empty),
    .err(err), .err_code(err_code)
  );

  typedef struct {
    logic [K-1:0] top;
    logic [K-1:0] second;
    int           count;
    bit           full;
    bit           empty;
    bit           err;
    logic [1:0]   code;
  } exp_t;

  exp_t         sb_q[$];
  int           errors = 0;
  int           checks = 0;
  logic [K-1:0] stk[$];
  bit           m_err = 1'b0;
  logic [1:0]   m_code = 2'b00;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference model: stack as a queue, errors per the command rules.
  task automatic model_step(input bit rn, input logic [1:0] c, input logic [K-1:0] d, input bit clr);
    if (!rn) begin
      stk.delete();
      m_err  = 1'b0;
      m_code = 2'b00;
    end else if (m_err) begin
      if (clr) begin
        m_err  = 1'b0;
        m_code = 2'b00;
      end
    end else begin
      case (c)
        PSH: if (stk.size() == DEPTH) begin m_err = 1'b1; m_code = 2'b01; end
             else stk.push_back(d);
        POP: if (stk.size() == 0) begin m_err = 1'b1; m_code = 2'b10; end
             else void'(stk.pop_back());
        RED: if (stk.size() < 2) begin m_err = 1'b1; m_code = 2'b10; end
             else begin void'(stk.pop_back()); void'(stk.pop_back()); stk.push_back(d); end
        default: ;
      endcase
    end
  endtask

  task automatic apply(input bit rn, input logic [1:0] c, input logic [K-1:0] d, input bit clr);
    exp_t e;
    int   n;
    @(negedge clk);
    rst_n = rn; cmd = c; din = d; clear_err = clr;
    @(posedge clk);
    model_step(rn, c, d, clr);
    n = stk.size();
    e.top    = (n >= 1) ? stk[n-1] : '0;
    e.second = (n >= 2) ? stk[n-2] : '0;
    e.count  = n;
    e.full   = (n == DEPTH);
    e.empty  = (n == 0);
    e.err    = m_err;
    e.code   = m_code;
    sb_q.push_back(e);
  endtask

  // Monitor: registered outputs settle right after the edge that consumed the command.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("top",      32'(top),      32'(e.top));
        chk("second",   32'(second),   32'(e.second));
        chk("count",    32'(count),    32'(e.count));
        chk("full",     32'(full),     32'(e.full));
        chk("empty",    32'(empty),    32'(e.empty));
        chk("err",      32'(err),      32'(e.err));
        chk("err_code", 32'(err_code), 32'(e.code));
      end
    end
  end

  initial begin
    int r;
    logic [1:0] c;
    apply(1'b0, NOP, '0, 1'b0);
    apply(1'b0, PSH, 16'h00aa, 1'b0);
    // Push 3, push 4, reduce 7, pop
    apply(1'b1, PSH, 16'd3, 1'b0);
    apply(1'b1, PSH, 16'd4, 1'b0);
    apply(1'b1, RED, 16'd7, 1'b0);
    apply(1'b1, POP, '0, 1'b0);
    // Fill, overflow, frozen pop, clear, pop
    for (int i = 1; i <= DEPTH; i++) apply(1'b1, PSH, 16'(i), 1'b0);
    apply(1'b1, PSH, 16'd9, 1'b0);
    apply(1'b1, POP, '0, 1'b0);
    apply(1'b1, NOP, '0, 1'b1);
    apply(1'b1, POP, '0, 1'b0);
    // Reduce at full depth is legal
    apply(1'b1, PSH, 16'h0bee, 1'b0);
    apply(1'b1, RED, 16'h1234, 1'b0);
    // Underflow cases
    apply(1'b0, NOP, '0, 1'b0);
    apply(1'b1, POP, '0, 1'b0);
    apply(1'b1, NOP, '0, 1'b1);
    apply(1'b1, PSH, 16'd5, 1'b0);
    apply(1'b1, RED, 16'd1, 1'b0);
    // clear_err with a command: only the clear happens; then the push is accepted
    apply(1'b1, PSH, 16'd2, 1'b1);
    apply(1'b1, PSH, 16'd2, 1'b0);
    // clear_err in RUN is ignored
    apply(1'b1, PSH, 16'd6, 1'b1);
    // Reset overrides a same-cycle push
    apply(1'b1, PSH, 16'd9, 1'b0);
    apply(1'b0, PSH, 16'd9, 1'b0);
    apply(1'b1, NOP, '0, 1'b0);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 40)      c = PSH;
      else if (r < 65) c = POP;
      else if (r < 85) c = RED;
      else             c = NOP;
      apply(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1, c, K'($urandom),
            ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
    end
    apply(1'b1, NOP, '0, 1'b0);
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
